// File: rtl/sx1278_spi_pkg.sv
// Shared types and constants for the SX1278-style SPI register responder.
// Frame = address byte (bit7 = write-not-read) followed by data bytes.
package sx1278_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int WNR_BIT = 7;

  localparam logic [6:0] REG_FIFO    = 7'h00;
  localparam logic [6:0] REG_OP_MODE = 7'h01;
  localparam logic [6:0] REG_VERSION = 7'h42;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous input, plus a history flop
// that yields single-cycle rise/fall pulses on the synchronised level.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      hist  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      hist  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/sx1278_spi_responder.sv
// SPI mode-0 target answering SX1278-style register frames, oversampled in clk_in.
// Address byte selects register and direction; following bytes burst with auto-increment.
module sx1278_spi_responder
  import sx1278_spi_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              sclk,
  input  logic              nss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              frame_err
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [1:0]        rst_pipe;
  logic              rst_int;
  logic              sclk_rise, sclk_fall, sclk_level;
  logic              nss_sync, nss_rise, nss_fall;
  logic              mosi_sync, mosi_rise_unused, mosi_fall_unused;
  state_t            state, state_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_byte;
  logic [DATA_W-1:0] tx_shift;
  logic              miso_q;
  logic              wnr;
  logic              load_pend;
  logic              shift_en, byte_done, addr_done, data_done, tx_step, abort_partial;

  // Reset asserts immediately but releases only after two clean clk_in edges.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) rst_pipe <= 2'b11;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst_int = rst_pipe[1];

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_in(clk_in), .rst(rst_int), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  // nss idles high so a reset never fakes a frame start.
  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nss (
    .clk_in(clk_in), .rst(rst_int), .din(nss),
    .level(nss_sync), .rise(nss_rise), .fall(nss_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_in(clk_in), .rst(rst_int), .din(mosi),
    .level(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  always_ff @(posedge clk_in or posedge rst_int) begin
    if (rst_int) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (nss_rise)                      state_nx = IDLE;
    else if (nss_fall)                 state_nx = ADDR;
    else if (state == ADDR && byte_done) state_nx = DATA;
  end

  always_comb begin
    shift_en      = sclk_rise && !nss_sync && !nss_rise && !nss_fall && (state != IDLE);
    byte_done     = shift_en && (bit_cnt == LAST_BIT);
    addr_done     = byte_done && (state == ADDR);
    data_done     = byte_done && (state == DATA);
    tx_step       = sclk_fall && !nss_sync && !nss_rise && (state == DATA) && !wnr;
    abort_partial = nss_rise && (state != IDLE) && (bit_cnt != '0);
  end

  assign rx_byte = {rx_shift, mosi_sync};
  assign miso_oe = ~nss_sync;
  assign miso    = miso_q & miso_oe;

  always_ff @(posedge clk_in or posedge rst_int) begin
    if (rst_int) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      miso_q    <= 1'b0;
      wnr       <= 1'b0;
      load_pend <= 1'b0;
      reg_addr  <= '0;
      reg_re    <= 1'b0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
      frame_err <= 1'b0;
    end else begin
      reg_re    <= 1'b0;
      reg_we    <= 1'b0;
      frame_err <= abort_partial;
      load_pend <= reg_re;

      if (nss_fall || nss_rise) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (shift_en) begin
        bit_cnt  <= bit_cnt + CNT_W'(1);
        rx_shift <= rx_byte[DATA_W-2:0];
      end

      if (addr_done) begin
        wnr      <= rx_byte[WNR_BIT];
        reg_addr <= rx_byte[ADDR_W-1:0];
        reg_re   <= ~rx_byte[WNR_BIT];
      end

      if (data_done) begin
        if (wnr) begin
          reg_wdata <= rx_byte;
          reg_we    <= 1'b1;
        end else begin
          reg_addr <= reg_addr + ADDR_W'(1);
          reg_re   <= 1'b1;
        end
      end

      // Writes commit at the current address, then advance for the next burst byte.
      if (reg_we) reg_addr <= reg_addr + ADDR_W'(1);

      if (nss_fall) begin
        wnr      <= 1'b0;
        tx_shift <= '0;
        miso_q   <= 1'b0;
      end else if (load_pend) begin
        tx_shift <= reg_rdata;
      end else if (tx_step) begin
        miso_q   <= tx_shift[DATA_W-1];
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_sx1278_spi_responder.sv
// Directed bench for the SX1278 SPI responder: master BFM, register-file model,
// and a frame-level expectation model checked by one per-cycle compare process.
module tb_sx1278_spi_responder;
  import sx1278_spi_pkg::*;

  localparam int HALF = 500;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       sclk   = 1'b0;
  logic       nss    = 1'b1;
  logic       mosi   = 1'b0;
  logic       miso, miso_oe, reg_re, reg_we, frame_err;
  logic [6:0] reg_addr;
  logic [7:0] reg_rdata = 8'h00;
  logic [7:0] reg_wdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  mem [128];
  logic [14:0] exp_wr [$];
  logic [6:0]  exp_rd [$];
  logic [14:0] we_log [$];
  logic [6:0]  re_log [$];
  logic [7:0]  rx_bytes [3];
  logic [7:0]  exp_miso [3];
  int          exp_ferr = 0;
  int          seen_ferr = 0;

  always #10 clk_in = ~clk_in;

  sx1278_spi_responder dut (
    .clk_in(clk_in), .rst(rst), .sclk(sclk), .nss(nss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .reg_addr(reg_addr), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .reg_we(reg_we), .reg_wdata(reg_wdata), .frame_err(frame_err)
  );

  // Register file: registered read data, write on strobe.
  always @(posedge clk_in) begin
    if (reg_re) reg_rdata <= mem[reg_addr];
    if (reg_we) mem[reg_addr] <= reg_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got strobe with %0h required none", name, act);
  endtask

  always @(negedge clk_in) begin
    if (!rst) begin
      if (reg_we) begin
        we_log.push_back({reg_addr, reg_wdata});
        if (exp_wr.size() == 0) unexpected("reg_we", 32'({reg_addr, reg_wdata}));
        else check("reg_we addr/data", 32'({reg_addr, reg_wdata}), 32'(exp_wr.pop_front()));
      end
      if (reg_re) begin
        re_log.push_back(reg_addr);
        if (exp_rd.size() == 0) unexpected("reg_re", 32'(reg_addr));
        else check("reg_re addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
      end
      if (frame_err) begin
        seen_ferr++;
        if (seen_ferr > exp_ferr) unexpected("frame_err", 32'(seen_ferr));
      end
      if (!miso_oe) check("miso idle low", 32'(miso), 32'd0);
    end
  end

  // Frame-level model: what strobes and miso bytes a frame must produce.
  task automatic expect_frame(input logic [7:0] b0, b1, b2, input int n);
    logic [7:0] d [3];
    logic [6:0] a;
    d[0] = b0; d[1] = b1; d[2] = b2;
    a = b0[6:0];
    exp_miso[0] = 8'h00;
    for (int i = 1; i < n; i++) begin
      if (b0[7]) begin
        exp_wr.push_back({7'(a + 7'(i - 1)), d[i]});
        exp_miso[i] = 8'h00;
      end else begin
        exp_miso[i] = mem[7'(a + 7'(i - 1))];
      end
    end
    if (!b0[7])
      for (int i = 0; i < n; i++) exp_rd.push_back(7'(a + 7'(i)));
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int k = 7; k > 7 - nbits; k--) begin
      mosi = b[k];
      #(HALF);
      sclk = 1'b1;
      r[k] = miso;
      #(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b0, b1, b2, input int n);
    logic [7:0] d [3];
    logic [7:0] r;
    d[0] = b0; d[1] = b1; d[2] = b2;
    nss = 1'b0;
    #(HALF);
    for (int i = 0; i < n; i++) begin
      send_bits(d[i], 8, r);
      rx_bytes[i] = r;
    end
    #(HALF);
    check("miso_oe in frame", 32'(miso_oe), 32'd1);
    nss = 1'b1;
    #(4 * HALF);
    check("miso_oe after frame", 32'(miso_oe), 32'd0);
    for (int i = 0; i < n; i++) check("miso byte", 32'(rx_bytes[i]), 32'(exp_miso[i]));
    check("writes drained", 32'(exp_wr.size()), 32'd0);
    check("reads drained", 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] b0, b1, b2, input int n);
    we_log.delete();
    re_log.delete();
    expect_frame(b0, b1, b2, n);
    frame(b0, b1, b2, n);
  endtask

  task automatic check_reset_outputs();
    check("rst miso", 32'(miso), 32'd0);
    check("rst miso_oe", 32'(miso_oe), 32'd0);
    check("rst reg_addr", 32'(reg_addr), 32'd0);
    check("rst reg_re", 32'(reg_re), 32'd0);
    check("rst reg_we", 32'(reg_we), 32'd0);
    check("rst reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst frame_err", 32'(frame_err), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    mem[7'h42] = 8'h12;

    repeat (5) @(negedge clk_in);
    check_reset_outputs();
    check("rst state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    repeat (10) @(negedge clk_in);

    // Single write
    run_frame(8'h81, 8'h88, 8'h00, 2);
    check("wr count", 32'(we_log.size()), 32'd1);
    if (we_log.size() > 0) check("wr literal", 32'(we_log[0]), 32'({7'h01, 8'h88}));

    // Single read, register 0x42 holds 0x12
    run_frame(8'h42, 8'h00, 8'h00, 2);
    check("rd miso literal", 32'(rx_bytes[1]), 32'h12);
    if (re_log.size() > 0) check("rd addr literal", 32'(re_log[0]), 32'h42);

    // Burst write with address wrap 0x7F -> 0x00
    run_frame(8'hFF, 8'hAA, 8'h55, 3);
    check("bwr count", 32'(we_log.size()), 32'd2);
    if (we_log.size() > 1) begin
      check("bwr first", 32'(we_log[0]), 32'({7'h7F, 8'hAA}));
      check("bwr second", 32'(we_log[1]), 32'({7'h00, 8'h55}));
    end

    // Burst read, rdata = addr
    run_frame(8'h40, 8'h00, 8'h00, 3);
    check("brd byte0 literal", 32'(rx_bytes[1]), 32'h40);
    check("brd byte1 literal", 32'(rx_bytes[2]), 32'h41);
    check("brd re count", 32'(re_log.size()), 32'd3);

    // sclk toggling while nss high must be ignored
    we_log.delete();
    re_log.delete();
    mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #(HALF); sclk = 1'b1; #(HALF); sclk = 1'b0;
    end
    #(4 * HALF);
    check("idle sclk no we", 32'(we_log.size()), 32'd0);
    check("idle sclk no re", 32'(re_log.size()), 32'd0);
    check("idle sclk state", 32'(dut.state), 32'(IDLE));

    // Write frame aborted after 5 data bits
    we_log.delete();
    exp_ferr  = 1;
    seen_ferr = 0;
    nss = 1'b0;
    #(HALF);
    send_bits(8'h81, 8, r);
    send_bits(8'hF0, 5, r);
    #(HALF);
    nss = 1'b1;
    #(4 * HALF);
    check("abort frame_err cycles", 32'(seen_ferr), 32'd1);
    check("abort no we", 32'(we_log.size()), 32'd0);
    check("abort state", 32'(dut.state), 32'(IDLE));

    // Reset in the middle of a data byte
    nss = 1'b0;
    #(HALF);
    send_bits(8'h81, 8, r);
    send_bits(8'hC3, 4, r);
    rst = 1'b1;
    nss = 1'b1;
    repeat (3) @(negedge clk_in);
    check_reset_outputs();
    rst = 1'b0;
    repeat (10) @(negedge clk_in);
    check("post-rst state", 32'(dut.state), 32'(IDLE));
    run_frame(8'h81, 8'h01, 8'h00, 2);
    check("post-rst wr count", 32'(we_log.size()), 32'd1);
    if (we_log.size() > 0) check("post-rst wr literal", 32'(we_log[0]), 32'({7'h01, 8'h01}));
    check("frame_err total", 32'(seen_ferr), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #(5_000_000);
    $display("FAIL timeout: got still running required finished");
    $fatal(1, "timeout");
  end

endmodule
